// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 arbiter: NM masters share one slave port, grant held per CYC,
// with a per-grant response watchdog that terminates hung cycles with ERR.
module wb_rr_arbiter #(
  parameter int NM      = 2,
  parameter int aw      = 32,
  parameter int dw      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [NM*aw-1:0]   wbm_adr_i,
  input  logic [NM*dw-1:0]   wbm_dat_i,
  input  logic [NM*dw/8-1:0] wbm_sel_i,
  input  logic [NM-1:0]      wbm_we_i,
  input  logic [NM-1:0]      wbm_cyc_i,
  input  logic [NM-1:0]      wbm_stb_i,
  input  logic [NM*3-1:0]    wbm_cti_i,
  input  logic [NM*2-1:0]    wbm_bte_i,
  output logic [dw-1:0]      wbm_dat_o,
  output logic [NM-1:0]      wbm_ack_o,
  output logic [NM-1:0]      wbm_err_o,
  output logic [NM-1:0]      wbm_rty_o,
  output logic [aw-1:0]      wbs_adr_o,
  output logic [dw-1:0]      wbs_dat_o,
  output logic [dw/8-1:0]    wbs_sel_o,
  output logic               wbs_we_o,
  output logic               wbs_cyc_o,
  output logic               wbs_stb_o,
  output logic [2:0]         wbs_cti_o,
  output logic [1:0]         wbs_bte_o,
  input  logic [dw-1:0]      wbs_dat_i,
  input  logic               wbs_ack_i,
  input  logic               wbs_err_i,
  input  logic               wbs_rty_i,
  output logic [NM-1:0]      grant_o
);

  localparam int OW    = $clog2(NM);
  localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WD_EN = (TIMEOUT > 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [OW-1:0] last_q, last_d;     // last owner; doubles as current owner while BUSY
  logic [OW-1:0] arb_idx;
  logic          arb_found;
  logic [CW-1:0] wd_cnt_q;
  logic          to_err_q;

  logic busy, own_cyc, own_stb, slv_resp;

  assign busy     = (state_q == BUSY);
  assign own_cyc  = wbm_cyc_i[last_q];
  assign own_stb  = wbm_stb_i[last_q];
  assign slv_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;

  // First requester searching upward from last+1, wrapping modulo NM.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = last_q;
    for (int i = 1; i <= NM; i++) begin
      if (!arb_found && wbm_cyc_i[(int'(last_q) + i) % NM]) begin
        arb_found = 1'b1;
        arb_idx   = OW'((int'(last_q) + i) % NM);
      end
    end
  end

  // NOTE: async reset in the sensitivity list and <= for every register, so all
  // state updates land together at the edge regardless of statement order.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= IDLE;
      last_q  <= OW'(NM - 1);
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d = BUSY;
          last_d  = arb_idx;
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          if (arb_found) last_d  = arb_idx;
          else           state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter only runs while the owner holds a live strobe; a response wins over expiry.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wd_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else if (WD_EN && busy && own_cyc && own_stb && !to_err_q && !slv_resp) begin
      if (wd_cnt_q == CW'(TIMEOUT - 1)) begin
        wd_cnt_q <= '0;
        to_err_q <= 1'b1;
      end else begin
        wd_cnt_q <= wd_cnt_q + 1'b1;
        to_err_q <= 1'b0;
      end
    end else begin
      wd_cnt_q <= '0;
      to_err_q <= 1'b0;
    end
  end

  assign wbm_dat_o = wbs_dat_i;

  always_comb begin
    grant_o   = '0;
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_rty_o = '0;
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    if (busy) begin
      grant_o[last_q]   = 1'b1;
      wbs_adr_o         = wbm_adr_i[last_q*aw +: aw];
      wbs_dat_o         = wbm_dat_i[last_q*dw +: dw];
      wbs_sel_o         = wbm_sel_i[last_q*(dw/8) +: dw/8];
      wbs_we_o          = wbm_we_i[last_q];
      wbs_cti_o         = wbm_cti_i[last_q*3 +: 3];
      wbs_bte_o         = wbm_bte_i[last_q*2 +: 2];
      wbs_cyc_o         = own_cyc & ~to_err_q;
      wbs_stb_o         = own_stb & ~to_err_q;
      wbm_ack_o[last_q] = wbs_ack_i;
      wbm_err_o[last_q] = wbs_err_i | to_err_q;
      wbm_rty_o[last_q] = wbs_rty_i;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: NM=4, one instance with TIMEOUT=4 and one with
// the watchdog disabled, both driven by the same master/slave stimulus.
module tb_wb_rr_arbiter;
  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i = 1'b0;
  logic [NM*AW-1:0]  wbm_adr_i;
  logic [NM*DW-1:0]  wbm_dat_i;
  logic [NM*DW/8-1:0] wbm_sel_i;
  logic [NM-1:0]     wbm_we_i;
  logic [NM-1:0]     wbm_cyc_i;
  logic [NM-1:0]     wbm_stb_i;
  logic [NM*3-1:0]   wbm_cti_i;
  logic [NM*2-1:0]   wbm_bte_i;
  logic [DW-1:0]     wbs_dat_i;
  logic              wbs_ack_i, wbs_err_i, wbs_rty_i;

  logic [DW-1:0]     wbm_dat_o, n_wbm_dat_o;
  logic [NM-1:0]     wbm_ack_o, wbm_err_o, wbm_rty_o, grant_o;
  logic [NM-1:0]     n_wbm_ack_o, n_wbm_err_o, n_wbm_rty_o, n_grant_o;
  logic [AW-1:0]     wbs_adr_o, n_wbs_adr_o;
  logic [DW-1:0]     wbs_dat_o, n_wbs_dat_o;
  logic [DW/8-1:0]   wbs_sel_o, n_wbs_sel_o;
  logic              wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic              n_wbs_we_o, n_wbs_cyc_o, n_wbs_stb_o;
  logic [2:0]        wbs_cti_o, n_wbs_cti_o;
  logic [1:0]        wbs_bte_o, n_wbs_bte_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_rr_arbiter #(.NM(NM), .aw(AW), .dw(DW), .TIMEOUT(4)) u_dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
    .grant_o(grant_o)
  );

  wb_rr_arbiter #(.NM(NM), .aw(AW), .dw(DW), .TIMEOUT(0)) u_dut_nowd (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_dat_o(n_wbm_dat_o), .wbm_ack_o(n_wbm_ack_o), .wbm_err_o(n_wbm_err_o), .wbm_rty_o(n_wbm_rty_o),
    .wbs_adr_o(n_wbs_adr_o), .wbs_dat_o(n_wbs_dat_o), .wbs_sel_o(n_wbs_sel_o), .wbs_we_o(n_wbs_we_o),
    .wbs_cyc_o(n_wbs_cyc_o), .wbs_stb_o(n_wbs_stb_o), .wbs_cti_o(n_wbs_cti_o), .wbs_bte_o(n_wbs_bte_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
    .grant_o(n_grant_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #2;
  endtask

  task automatic set_req(input int m, input logic v);
    wbm_cyc_i[m] = v;
    wbm_stb_i[m] = v;
  endtask

  function automatic logic [31:0] m_adr(input int m);
    return 32'hA000_0000 | (32'(m) << 8);
  endfunction

  initial begin
    for (int m = 0; m < NM; m++) begin
      wbm_adr_i[m*AW +: AW]  = m_adr(m);
      wbm_dat_i[m*DW +: DW]  = 32'hD000_0000 + 32'(m);
      wbm_sel_i[m*4 +: 4]    = 4'hF ^ 4'(m);
    end
    wbm_we_i  = 4'b0101;
    wbm_cyc_i = '0;
    wbm_stb_i = '0;
    wbm_cti_i = '0;
    wbm_bte_i = '0;
    wbs_dat_i = 32'h5A5A_1234;
    wbs_ack_i = 1'b1;
    wbs_err_i = 1'b0;
    wbs_rty_i = 1'b0;

    // Reset holds everything low even with requests and a slave ACK present.
    set_req(1, 1'b1);
    set_req(3, 1'b1);
    repeat (3) tick();
    check("rst_grant", grant_o, 4'b0000);
    check("rst_wbs_cyc", wbs_cyc_o, 1'b0);
    check("rst_wbs_adr", wbs_adr_o, 32'h0);
    check("rst_ack", wbm_ack_o, 4'b0000);
    wbs_ack_i = 1'b0;

    // First grant: master 0 highest priority, so 1010 picks master 1.
    wb_rst_i = 1'b1;
    #1;
    check("grant_latency", grant_o, 4'b0000);
    tick();
    check("first_grant", grant_o, 4'b0010);
    check("first_adr", wbs_adr_o, m_adr(1));
    check("first_dat", wbs_dat_o, 32'hD000_0001);
    check("first_sel", wbs_sel_o, 4'hE);
    check("first_we", wbs_we_o, 1'b0);
    check("first_stb", wbs_stb_o, 1'b1);
    check("rd_dat_bcast", wbm_dat_o, 32'h5A5A_1234);
    wbs_ack_i = 1'b1;
    #1;
    check("first_ack_route", wbm_ack_o, 4'b0010);
    tick();
    wbs_ack_i = 1'b0;
    set_req(1, 1'b0);
    tick();
    check("second_grant", grant_o, 4'b1000);
    check("second_adr", wbs_adr_o, m_adr(3));
    wbs_rty_i = 1'b1;
    #1;
    check("rty_route", wbm_rty_o, 4'b1000);
    tick();
    wbs_rty_i = 1'b0;
    set_req(3, 1'b0);
    tick();
    check("back_to_idle", grant_o, 4'b0000);

    // Round robin with all four requesting; owner re-requests after its handover.
    for (int m = 0; m < NM; m++) set_req(m, 1'b1);
    tick();
    for (int k = 0; k < 6; k++) begin
      int e;
      e = k % NM;
      check($sformatf("rr_grant_%0d", k), grant_o, 64'(1 << e));
      check($sformatf("rr_adr_%0d", k), wbs_adr_o, m_adr(e));
      wbs_ack_i = 1'b1;
      #1;
      check($sformatf("rr_ack_%0d", k), wbm_ack_o, 64'(1 << e));
      tick();
      wbs_ack_i = 1'b0;
      set_req(e, 1'b0);
      tick();
      set_req(e, 1'b1);
    end
    for (int m = 0; m < NM; m++) set_req(m, 1'b0);
    tick();
    check("rr_idle", grant_o, 4'b0000);

    // Burst atomicity: master 2 runs 8 beats while master 0 waits.
    set_req(2, 1'b1);
    wbm_cti_i[6 +: 3] = 3'b010;
    tick();
    check("burst_grant", grant_o, 4'b0100);
    set_req(0, 1'b1);
    wbs_ack_i = 1'b1;
    for (int b = 0; b < 8; b++) begin
      wbm_cti_i[6 +: 3] = (b == 7) ? 3'b111 : 3'b010;
      #1;
      check($sformatf("burst_cti_%0d", b), wbs_cti_o, (b == 7) ? 3'b111 : 3'b010);
      check($sformatf("burst_ack_%0d", b), wbm_ack_o, 4'b0100);
      tick();
    end
    check("burst_hold", grant_o, 4'b0100);
    wbs_ack_i = 1'b0;
    set_req(2, 1'b0);
    wbm_cti_i[6 +: 3] = 3'b000;
    tick();
    check("burst_handoff", grant_o, 4'b0001);
    wbs_ack_i = 1'b1;
    tick();
    wbs_ack_i = 1'b0;
    set_req(0, 1'b0);
    tick();
    check("burst_idle", grant_o, 4'b0000);

    // Watchdog: slave never answers master 3.
    set_req(3, 1'b1);
    tick();
    check("wd_grant", grant_o, 4'b1000);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("wd_err_%0d", c), wbm_err_o, (c == 4) ? 4'b1000 : 4'b0000);
      check($sformatf("wd_stb_%0d", c), wbs_stb_o, (c == 4) ? 1'b0 : 1'b1);
      check($sformatf("wd_cyc_%0d", c), wbs_cyc_o, (c == 4) ? 1'b0 : 1'b1);
      check($sformatf("nowd_err_%0d", c), n_wbm_err_o, 4'b0000);
      check($sformatf("nowd_stb_%0d", c), n_wbs_stb_o, 1'b1);
    end
    check("wd_keeps_grant", grant_o, 4'b1000);
    set_req(3, 1'b0);
    tick();
    check("wd_err_once", wbm_err_o, 4'b0000);
    check("wd_idle", grant_o, 4'b0000);

    // Collision: ACK in the cycle the count would reach TIMEOUT wins.
    set_req(3, 1'b1);
    tick();
    for (int c = 1; c <= 3; c++) begin
      tick();
      check($sformatf("col_err_%0d", c), wbm_err_o, 4'b0000);
    end
    wbs_ack_i = 1'b1;
    #1;
    check("col_ack", wbm_ack_o, 4'b1000);
    check("col_no_err_now", wbm_err_o, 4'b0000);
    tick();
    wbs_ack_i = 1'b0;
    check("col_no_err", wbm_err_o, 4'b0000);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("col_restart_%0d", c), wbm_err_o, (c == 4) ? 4'b1000 : 4'b0000);
    end
    set_req(3, 1'b0);
    tick();

    // Reset during beat 3 of master 1's burst.
    set_req(1, 1'b1);
    wbm_cti_i[3 +: 3] = 3'b010;
    tick();
    check("rstb_grant", grant_o, 4'b0010);
    wbs_ack_i = 1'b1;
    repeat (3) tick();
    wb_rst_i = 1'b0;
    #1;
    check("rstb_grant_clr", grant_o, 4'b0000);
    check("rstb_cyc_clr", wbs_cyc_o, 1'b0);
    check("rstb_stb_clr", wbs_stb_o, 1'b0);
    check("rstb_adr_clr", wbs_adr_o, 32'h0);
    check("rstb_cti_clr", wbs_cti_o, 3'b000);
    check("rstb_ack_clr", wbm_ack_o, 4'b0000);
    wbs_ack_i = 1'b0;
    wbm_cti_i = '0;
    set_req(3, 1'b1);
    tick();
    wb_rst_i = 1'b1;
    tick();
    check("rstb_regrant", grant_o, 4'b0010);
    check("rstb_regrant_adr", wbs_adr_o, m_adr(1));
    for (int m = 0; m < NM; m++) set_req(m, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
